// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: bundle of every non-clock/reset signal of the fetch stage.
//   slave  modport: the fetch stage itself (ifetch_queue)
//   master modport: its environment (ROB, ICache, branch predictor, decoder)
// Signals:
//   rdy, jump_wrong, jump_pc_from_rob      global enable and ROB redirect
//   icache_enable, pc_to_fetch              fetch request to ICache
//   instr_fetched, icache_success           ICache response
//   instr_to_predictor, instr_pc_to_predictor, is_jump_instr,
//   jump_prediction, jump_pc_from_predictor branch predictor lookup
//   stall_IF, IF_success, instr_to_decode,
//   pc_to_decoder, pred_taken_to_decoder    queue head to decoder
interface ifetch_queue_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) ();
  logic               rdy;
  logic               jump_wrong;
  logic [ADDR_W-1:0]  jump_pc_from_rob;
  logic               icache_enable;
  logic [ADDR_W-1:0]  pc_to_fetch;
  logic [INSTR_W-1:0] instr_fetched;
  logic               icache_success;
  logic [INSTR_W-1:0] instr_to_predictor;
  logic [ADDR_W-1:0]  instr_pc_to_predictor;
  logic               is_jump_instr;
  logic               jump_prediction;
  logic [ADDR_W-1:0]  jump_pc_from_predictor;
  logic               stall_IF;
  logic               IF_success;
  logic [INSTR_W-1:0] instr_to_decode;
  logic [ADDR_W-1:0]  pc_to_decoder;
  logic               pred_taken_to_decoder;

  modport slave (
    input  rdy, jump_wrong, jump_pc_from_rob, instr_fetched, icache_success,
           is_jump_instr, jump_prediction, jump_pc_from_predictor, stall_IF,
    output icache_enable, pc_to_fetch, instr_to_predictor, instr_pc_to_predictor,
           IF_success, instr_to_decode, pc_to_decoder, pred_taken_to_decoder
  );

  modport master (
    output rdy, jump_wrong, jump_pc_from_rob, instr_fetched, icache_success,
           is_jump_instr, jump_prediction, jump_pc_from_predictor, stall_IF,
    input  icache_enable, pc_to_fetch, instr_to_predictor, instr_pc_to_predictor,
           IF_success, instr_to_decode, pc_to_decoder, pred_taken_to_decoder
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage with a decoupling instruction queue.
// Keeps one ICache request in flight, steers the next PC from the branch
// predictor on every response and buffers {instr, pc, taken} entries in a
// QUEUE_DEPTH-entry FIFO read by the decoder. A ROB mispredict (jump_wrong)
// flushes the queue and discards any stale in-flight response.
// Ports:
//   clk  single clock, all state on posedge
//   rst  synchronous active-high reset
//   bus  ifetch_queue_if.slave (ICache, predictor, decoder and ROB signals)
// Optional feature: define IFQ_BYPASS_EN to forward a response straight to
// the decoder in the acknowledge cycle when the queue is empty.
module ifetch_queue #(
  parameter int              ADDR_W      = 32,
  parameter int              INSTR_W     = 32,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic           clk,
  input logic           rst,
  ifetch_queue_if.slave bus
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               req_en_q, req_en_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;

  logic [INSTR_W-1:0]   instr_mem_q [QUEUE_DEPTH];
  logic [ADDR_W-1:0]    pc_mem_q    [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] taken_mem_q;

  logic               flush;
  logic               taken;
  logic [ADDR_W-1:0]  next_pc;
  logic               resp_ok;
  logic               bypass;
  logic               queue_valid;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   count_after;
  logic               room_after;

  // Event decode: everything here is qualified by rdy, so a frozen cycle
  // produces no push, pop or flush.
  assign flush       = bus.rdy & bus.jump_wrong;
  assign taken       = bus.is_jump_instr & bus.jump_prediction;
  assign next_pc     = taken ? bus.jump_pc_from_predictor : pc_q + ADDR_W'(4);
  assign resp_ok     = bus.rdy & bus.icache_success & (state_q == S_BUSY) & ~bus.jump_wrong;
`ifdef IFQ_BYPASS_EN
  assign bypass      = resp_ok & (count_q == '0) & ~bus.stall_IF;
`else
  assign bypass      = 1'b0;
`endif
  assign queue_valid = bus.rdy & ~bus.jump_wrong & (count_q != '0);
  assign push        = resp_ok & ~bypass;
  assign pop         = queue_valid & ~bus.stall_IF;
  assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);
  // Using the post-pop count in IDLE lets a request issue in the cycle
  // right after the pop that frees a slot.
  assign room_after  = count_after < CNT_W'(QUEUE_DEPTH);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      req_en_q <= 1'b0;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      req_en_q <= req_en_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  // Queue storage carries no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[tail_q] <= bus.instr_fetched;
      pc_mem_q[tail_q]    <= pc_q;
      taken_mem_q[tail_q] <= taken;
    end
  end

  // Next-state: request FSM and fetch PC
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    req_en_d = req_en_q;
    if (bus.rdy) begin
      if (bus.jump_wrong) begin
        pc_d = bus.jump_pc_from_rob;
        unique case (state_q)
          S_IDLE: begin
            state_d  = S_BUSY;
            req_en_d = 1'b1;
            req_pc_d = bus.jump_pc_from_rob;
          end
          S_BUSY: begin
            if (bus.icache_success) begin
              req_en_d = 1'b1;
              req_pc_d = bus.jump_pc_from_rob;
            end else begin
              // Old request stays on the bus until the ICache acknowledges it.
              state_d = S_DROP;
            end
          end
          default: ;
        endcase
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (room_after) begin
              state_d  = S_BUSY;
              req_en_d = 1'b1;
              req_pc_d = pc_q;
            end
          end
          S_BUSY: begin
            if (bus.icache_success) begin
              pc_d = next_pc;
              if (room_after) begin
                req_pc_d = next_pc;
              end else begin
                req_en_d = 1'b0;
                state_d  = S_IDLE;
              end
            end
          end
          default: begin
            if (bus.icache_success) begin
              state_d  = S_BUSY;
              req_en_d = 1'b1;
              req_pc_d = pc_q;
            end
          end
        endcase
      end
    end
  end

  // Next-state: queue pointers and occupancy
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      count_d = count_after;
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push) tail_d = tail_q + PTR_W'(1);
    end
  end

  // Outputs
  always_comb begin
    bus.icache_enable         = req_en_q;
    bus.pc_to_fetch           = req_pc_q;
    bus.instr_to_predictor    = bus.instr_fetched;
    bus.instr_pc_to_predictor = req_pc_q;
    bus.IF_success            = queue_valid | bypass;
    if (bypass) begin
      bus.instr_to_decode       = bus.instr_fetched;
      bus.pc_to_decoder         = pc_q;
      bus.pred_taken_to_decoder = taken;
    end else begin
      bus.instr_to_decode       = instr_mem_q[head_q];
      bus.pc_to_decoder         = pc_mem_q[head_q];
      bus.pred_taken_to_decoder = taken_mem_q[head_q];
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: self-checking bench for ifetch_queue. A behavioural model
// (SV queue of fetched entries plus in-flight/stale flags) and a small ICache
// model with configurable latency run alongside the DUT; outputs are compared
// every cycle shortly after the inputs are driven at the falling edge.
module tb_ifetch_queue;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  ifetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .QUEUE_DEPTH(DEPTH),
                 .RESET_PC(32'h0)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        taken;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_req_pc;
  logic        m_en, m_inflight, m_stale;

  logic        ic_busy;
  int unsigned ic_cnt;
  logic [31:0] ic_instr;
  int unsigned lat_min, lat_max;
  logic        poison_c;

  logic        t_rdy, t_stall, t_jw;
  logic [31:0] t_jpc;
  int          pred_mode;

  logic        s_ifs, s_en, s_taken;
  logic [31:0] s_pcdec, s_pcf;

  int checks = 0;
  int errors = 0;

  logic [31:0] dec_log[$];
  logic        dec_taken[$];
  logic [31:0] ack_log[$];

  function automatic logic [31:0] ifn(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rdy = 1'b1; bus.jump_wrong = 1'b0; bus.jump_pc_from_rob = '0;
    bus.icache_success = 1'b0; bus.instr_fetched = '0; bus.stall_IF = 1'b0;
    bus.is_jump_instr = 1'b0; bus.jump_prediction = 1'b0; bus.jump_pc_from_predictor = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_icache_enable", bus.icache_enable, 0);
    chk("rst_pc_to_fetch", bus.pc_to_fetch, 0);
    chk("rst_IF_success", bus.IF_success, 0);
    mq.delete();
    m_pc = 0; m_req_pc = 0; m_en = 0; m_inflight = 0; m_stale = 0;
    ic_busy = 0; ic_cnt = 0; ic_instr = 0;
    dec_log.delete(); dec_taken.delete(); ack_log.delete();
    t_rdy = 1; t_stall = 0; t_jw = 0; t_jpc = 0;
    rst = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, advance the models.
  task automatic cycle();
    logic ack, taken, byp, qv, pop;
    logic [31:0] tgt;
    ack = ic_busy && (ic_cnt == 0);
    bus.rdy = t_rdy; bus.stall_IF = t_stall;
    bus.jump_wrong = t_jw; bus.jump_pc_from_rob = t_jpc;
    bus.icache_success = ack;
    bus.instr_fetched = ack ? ic_instr : $urandom;
    case (pred_mode)
      0: begin bus.is_jump_instr = 0; bus.jump_prediction = 0; bus.jump_pc_from_predictor = 0; end
      1: begin
        bus.is_jump_instr = (m_req_pc == 32'h8);
        bus.jump_prediction = 1;
        bus.jump_pc_from_predictor = 32'h100;
      end
      default: begin
        bus.is_jump_instr = 1'($urandom_range(0, 1));
        bus.jump_prediction = 1'($urandom_range(0, 1));
        bus.jump_pc_from_predictor = $urandom & 32'hFFFF_FFFC;
      end
    endcase
    #1;
    s_ifs = bus.IF_success; s_en = bus.icache_enable; s_pcf = bus.pc_to_fetch;
    s_pcdec = bus.pc_to_decoder; s_taken = bus.pred_taken_to_decoder;
    taken = bus.is_jump_instr & bus.jump_prediction;
    tgt = bus.jump_pc_from_predictor;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = t_rdy && !t_jw && m_inflight && !m_stale && ack && (mq.size() == 0) && !t_stall;
`endif
    qv = t_rdy && !t_jw && (mq.size() != 0);
    chk("icache_enable", s_en, m_en);
    chk("pc_to_fetch", s_pcf, m_req_pc);
    chk("instr_pc_to_predictor", bus.instr_pc_to_predictor, m_req_pc);
    chk("instr_to_predictor", bus.instr_to_predictor, bus.instr_fetched);
    chk("IF_success", s_ifs, qv || byp);
    if (qv) begin
      chk("head_pc", s_pcdec, mq[0].pc);
      chk("head_instr", bus.instr_to_decode, mq[0].instr);
      chk("head_taken", s_taken, mq[0].taken);
    end else if (byp) begin
      chk("byp_pc", s_pcdec, m_pc);
      chk("byp_instr", bus.instr_to_decode, bus.instr_fetched);
      chk("byp_taken", s_taken, taken);
    end
    if (s_ifs && !t_stall) begin dec_log.push_back(s_pcdec); dec_taken.push_back(s_taken); end
    if (t_rdy && ack && m_inflight && !m_stale && !t_jw) ack_log.push_back(s_pcf);

    if (t_rdy) begin
      if (ic_busy) begin
        if (ic_cnt == 0) ic_busy = 0; else ic_cnt--;
      end else if (m_en) begin
        ic_busy = 1;
        ic_cnt = $urandom_range(lat_max, lat_min) - 1;
        ic_instr = (poison_c && m_req_pc == 32'hC) ? 32'hDEAD_BEEF : ifn(m_req_pc);
      end
      pop = qv && !t_stall;
      if (t_jw) begin
        mq.delete();
        m_pc = t_jpc;
        if (!m_inflight) begin m_inflight = 1; m_en = 1; m_req_pc = t_jpc; end
        else if (!m_stale) begin
          if (ack) m_req_pc = t_jpc; else m_stale = 1;
        end
      end else if (!m_inflight) begin
        if (pop) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin m_inflight = 1; m_en = 1; m_req_pc = m_pc; end
      end else if (m_stale) begin
        if (pop) void'(mq.pop_front());
        if (ack) begin m_stale = 0; m_req_pc = m_pc; end
      end else begin
        if (pop) void'(mq.pop_front());
        if (ack) begin
          if (!byp) mq.push_back('{instr: bus.instr_fetched, pc: m_pc, taken: taken});
          m_pc = taken ? tgt : m_pc + 32'd4;
          if (mq.size() < DEPTH) m_req_pc = m_pc;
          else begin m_en = 0; m_inflight = 0; end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic found, saw200;
    logic [31:0] hold_pcf;
    int n_c;
    poison_c = 0; pred_mode = 0; lat_min = 1; lat_max = 1;
    @(negedge clk);

    // Straight-line fetch, 1-cycle ICache
    do_reset();
    repeat (12) cycle();
    chk("a_ack_pc0", ack_log[0], 32'h0);
    chk("a_ack_pc1", ack_log[1], 32'h4);
    chk("a_ack_pc2", ack_log[2], 32'h8);
    chk("a_dec_pc0", dec_log[0], 32'h0);
    chk("a_dec_pc1", dec_log[1], 32'h4);
    chk("a_dec_pc2", dec_log[2], 32'h8);

    // Decoder stalled: queue fills, fetch stops, release drains in order
    do_reset();
    t_stall = 1;
    repeat (20) cycle();
    chk("b_accepts", ack_log.size(), DEPTH);
    chk("b_en_off", s_en, 0);
    chk("b_head_valid", s_ifs, 1);
    chk("b_head_pc", s_pcdec, 32'h0);
    t_stall = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("b_pop_valid", s_ifs, 1);
      chk("b_pop_pc", s_pcdec, 32'(4 * i));
      if (i == 1) chk("b_resume_0x10", {s_en, s_pcf}, {1'b1, 32'h10});
    end

    // Predicted-taken branch at 0x8 -> 0x100
    do_reset();
    pred_mode = 1;
    repeat (14) cycle();
    chk("c_fetch_8", ack_log[2], 32'h8);
    chk("c_fetch_100", ack_log[3], 32'h100);
    chk("c_dec_8", dec_log[2], 32'h8);
    chk("c_dec_8_taken", dec_taken[2], 1);
    chk("c_dec_4_taken", dec_taken[1], 0);
    chk("c_dec_100", dec_log[3], 32'h100);
    pred_mode = 0;

    // Redirect while the request for 0xC is outstanding
    do_reset();
    lat_min = 3; lat_max = 3; poison_c = 1;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (ic_busy && ic_cnt == 2 && m_req_pc == 32'hC) begin found = 1; break; end
      cycle();
    end
    chk("d_reach_0xC", found, 1);
    t_jw = 1; t_jpc = 32'h200;
    cycle();
    chk("d_flush_empty", s_ifs, 0);
    t_jw = 0;
    dec_log.delete();
    saw200 = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (s_en && s_pcf == 32'h200) saw200 = 1;
    end
    n_c = 0;
    foreach (dec_log[i]) if (dec_log[i] == 32'hC) n_c++;
    chk("d_no_0xC_decoded", n_c, 0);
    chk("d_req_0x200", saw200, 1);
    chk("d_first_dec_0x200", dec_log[0], 32'h200);
    poison_c = 0; lat_min = 1; lat_max = 1;

    // rdy low for 3 cycles mid-stream
    do_reset();
    repeat (7) cycle();
    hold_pcf = m_req_pc;
    t_rdy = 0;
    repeat (3) begin
      cycle();
      chk("e_frozen_ifs", s_ifs, 0);
      chk("e_frozen_pcf", s_pcf, hold_pcf);
    end
    t_rdy = 1;
    repeat (12) cycle();
    chk("e_dec_count", dec_log.size() >= 6, 1);
    foreach (dec_log[i]) chk("e_dec_seq", dec_log[i], 32'(4 * i));

`ifdef IFQ_BYPASS_EN
    // Bypass: empty queue, response for 0x40 decoded in the ack cycle
    do_reset();
    cycle();
    t_jw = 1; t_jpc = 32'h40;
    cycle();
    t_jw = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (ic_busy && ic_cnt == 0 && m_req_pc == 32'h40 && !m_stale) begin found = 1; break; end
      cycle();
    end
    chk("g_reach_0x40", found, 1);
    cycle();
    chk("g_byp_valid", s_ifs, 1);
    chk("g_byp_pc", s_pcdec, 32'h40);
    chk("g_queue_empty", mq.size(), 0);
`endif

    // Randomised traffic
    do_reset();
    lat_min = 1; lat_max = 3; pred_mode = 2;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      t_rdy = ($urandom_range(0, 9) != 0);
      t_stall = ($urandom_range(0, 3) == 0);
      t_jw = ($urandom_range(0, 19) == 0);
      t_jpc = $urandom & 32'hFFFF_FFFC;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch stage with a decoupling instruction queue, replacing the single-entry fetch register between ICache and decoder. It keeps one ICache request in flight and steers the next PC from the branch predictor on every returned instruction. Fetched {instr, pc, prediction} entries are buffered in a FIFO so ICache latency and decoder back-pressure (`stall_IF`) overlap. A ROB mispredict flushes the queue and drops any stale in-flight response.

## Interface
- `ADDR_W`, 32, address width
- `INSTR_W`, 32, instruction width
- `QUEUE_DEPTH`, 4, queue entries; power of two, ≥2
- `RESET_PC`, 0, fetch PC after reset

Ports:
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: synchronous, active-high reset
- `rdy` in 1: global enable; 0 freezes all state
- `jump_wrong` in 1: ROB mispredict/flush
- `jump_pc_from_rob` in ADDR_W: redirect target
- `icache_enable` out 1: fetch request valid (registered)
- `pc_to_fetch` out ADDR_W: request address (registered, stable while waiting)
- `instr_fetched` in INSTR_W: ICache data
- `icache_success` in 1: one-cycle acknowledge of the current request
- `instr_to_predictor` out INSTR_W: equals `instr_fetched`
- `instr_pc_to_predictor` out ADDR_W: PC of the in-flight request
- `is_jump_instr`, `jump_prediction` in 1: predictor, combinational on the current response
- `jump_pc_from_predictor` in ADDR_W: predicted target
- `stall_IF` in 1: decoder/ROB/LSB full; blocks pop
- `IF_success` out 1: head entry valid to decoder
- `instr_to_decode` out INSTR_W, `pc_to_decoder` out ADDR_W, `pred_taken_to_decoder` out 1: head entry fields

## Operation
- Request FSM states: IDLE (nothing in flight), BUSY (request outstanding, response kept), DROP (request outstanding, response discarded).
- IDLE: if count < QUEUE_DEPTH, assert `icache_enable` and set `pc_to_fetch` = pc. Go to BUSY. This reserves one slot, and count cannot grow while BUSY.
- BUSY, `icache_success`:
  - Push {instr_fetched, pc, taken}, where taken = is_jump_instr & jump_prediction.
  - Next pc = taken ? jump_pc_from_predictor : pc + 4, modulo 2^ADDR_W.
  - If post-push/pop count < QUEUE_DEPTH, issue the next request on the same edge and stay BUSY.
  - Otherwise drop `icache_enable` and go to IDLE.
- DROP, `icache_success`: discard the response, issue a request for pc, go to BUSY.
- Pop: when `IF_success` & !`stall_IF`, advance the head pointer. Pointers wrap modulo QUEUE_DEPTH.
- `IF_success` = rdy & !jump_wrong & (count != 0). This is combinational; the head fields come straight from storage.
- `jump_wrong` has priority over all other events:
  - count ← 0 and pointers reset.
  - pc ← jump_pc_from_rob.
  - A concurrent push or pop is ignored.
  - IDLE: issue to jump_pc_from_rob, go to BUSY.
  - BUSY with `icache_success` the same cycle: discard the response, issue to jump_pc_from_rob, stay BUSY.
  - BUSY with no `icache_success`: go to DROP, holding the old `pc_to_fetch` until it is acknowledged.
  - DROP: update pc only, stay DROP.
- `rdy`=0: no state changes and `icache_success` is ignored. The ICache is frozen by the same `rdy`.
- Reset:
  - `icache_enable`=0, `pc_to_fetch`=RESET_PC, pc=RESET_PC, count=0, state IDLE.
  - `IF_success`=0, `instr_to_decode`/`pc_to_decoder`/`pred_taken_to_decoder` = entry 0 contents, which are don't-care.
  - Reset mid-request abandons it; the ICache is reset by the same `rst`.

## Timing
- First request: `icache_enable`=1 in the first cycle after `rst` falls with `rdy`=1.
- Response in cycle t:
  - Entry visible with `IF_success`=1 in cycle t+1.
  - Next request presented in cycle t+1, giving back-to-back fetch at one instruction per ICache latency.
- Redirect in cycle t: queue empty (`IF_success`=0) from t+1. Request to target at t+1, or one cycle after the stale acknowledge if in DROP.
- Full queue: the fetch stalls in IDLE. A request issues in the cycle after the pop that frees a slot.
- Simultaneous push and pop: count unchanged.

## Configuration
- `IFQ_BYPASS_EN` defined: when count==0, state BUSY, `icache_success`, !`jump_wrong`, !`stall_IF` and `rdy`, the response drives the decoder outputs in the same cycle with `IF_success`=1 and is not written to the queue. Zero-cycle fetch-to-decode latency.
- Undefined: every response is written; earliest `IF_success` is the cycle after the response.

## Test plan
- Reset, ICache acks every request after 1 cycle, no jumps, no stall -> `pc_to_fetch` 0,4,8,…; decoder receives pc 0,4,8 one cycle after each ack.
- `stall_IF`=1 held, depth 4 -> exactly 4 entries accepted, `icache_enable`=0 afterwards. Release -> pops 0,4,8,C in 4 cycles, then fetch of 0x10 resumes.
- Predictor asserts taken at pc 0x8 with target 0x100 -> next `pc_to_fetch`=0x100 and head entry for 0x8 has `pred_taken_to_decoder`=1.
- `jump_wrong` to 0x200 while request for 0xC is outstanding; ack arrives 2 cycles later with instr 0xDEADBEEF -> instr discarded, count=0, next request pc 0x200, no 0xC entry ever decoded.
- `rdy`=0 for 3 cycles mid-stream -> outputs and pointers unchanged, `IF_success`=0; sequence continues without loss or duplication.
- With `IFQ_BYPASS_EN`, empty queue, ack for pc 0x40 -> `IF_success`=1 with pc 0x40 in the ack cycle, count stays 0.
